// File: rtl/knn_distance_engine.sv
// kNN distance engine: latches one test vector, sweeps stored samples from synchronous memory
// and streams one squared-Euclidean or Manhattan distance per sample.
module knn_distance_engine #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_FEATURES = 8,
  parameter int unsigned NUM_SAMPLES  = 16,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned MEM_LATENCY  = 1,
  localparam int unsigned FW    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int unsigned ACC_W = 2 * DATA_WIDTH + FW,
  localparam int unsigned IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  metric_sel,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] test_feature,
  input  logic                  test_feature_valid,
  output logic                  test_feature_ready,
  output logic                  sample_rd_en,
  output logic [ADDR_WIDTH-1:0] sample_addr,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic [ACC_W-1:0]      dist_data,
  output logic [IDX_W-1:0]      dist_idx,
  output logic                  dist_valid,
  input  logic                  dist_ready
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_DRAIN, S_OUTPUT, S_DONE} state_e;

  localparam logic [FW-1:0]    F_LAST = FW'(NUM_FEATURES - 1);
  localparam logic [IDX_W-1:0] S_LAST = IDX_W'(NUM_SAMPLES - 1);

  state_e                 state_q, state_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [IDX_W-1:0]       samp_q, samp_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   rd_en_q, rd_en_d;
  logic                   dv_q, dv_d;
  logic [IDX_W-1:0]       didx_q, didx_d;
  logic [ACC_W-1:0]       ddata_q, ddata_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   tfr_q, tfr_d;
  logic                   metric_q, metric_d;
  logic                   acc_clr_c, test_we_c, flush_c;

  logic [DATA_WIDTH-1:0]  test_q [NUM_FEATURES];
  logic [MEM_LATENCY-1:0] vld_q;
  logic [FW-1:0]          fidx_q [MEM_LATENCY];
  logic [ACC_W-1:0]       acc_q;
  logic                   last_q;

  logic [DATA_WIDTH-1:0]   test_sel_c;
  logic [DATA_WIDTH:0]     diff_c;
  logic [DATA_WIDTH-1:0]   absd_c;
  logic [2*DATA_WIDTH-1:0] sq_c;
  logic [ACC_W-1:0]        term_c;

  // Next-state and registered-output logic; abort overrides every non-idle state.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    samp_d    = samp_q;
    addr_d    = addr_q;
    rd_en_d   = rd_en_q;
    dv_d      = dv_q;
    didx_d    = didx_q;
    ddata_d   = ddata_q;
    done_d    = 1'b0;
    metric_d  = metric_q;
    acc_clr_c = 1'b0;
    test_we_c = 1'b0;
    flush_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          metric_d = metric_sel;
          fcnt_d   = '0;
          samp_d   = '0;
          addr_d   = '0;
        end
      end
      S_LOAD: begin
        if (test_feature_valid && tfr_q) begin
          test_we_c = 1'b1;
          if (fcnt_q == F_LAST) begin
            state_d   = S_FETCH;
            fcnt_d    = '0;
            rd_en_d   = 1'b1;
            acc_clr_c = 1'b1;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end
      S_FETCH: begin
        if (fcnt_q == F_LAST) begin
          state_d = S_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (last_q) begin
          state_d = S_OUTPUT;
          dv_d    = 1'b1;
          didx_d  = samp_q;
          ddata_d = acc_q;
        end
      end
      S_OUTPUT: begin
        if (dist_ready) begin
          dv_d = 1'b0;
          if (samp_q == S_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_FETCH;
            samp_d    = samp_q + IDX_W'(1);
            fcnt_d    = '0;
            addr_d    = addr_q + ADDR_WIDTH'(1);
            rd_en_d   = 1'b1;
            acc_clr_c = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rd_en_d = 1'b0;
      dv_d    = 1'b0;
      done_d  = 1'b0;
      flush_c = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
    tfr_d  = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fcnt_q   <= '0;
      samp_q   <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      dv_q     <= 1'b0;
      didx_q   <= '0;
      ddata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tfr_q    <= 1'b0;
      metric_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      samp_q   <= samp_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      dv_q     <= dv_d;
      didx_q   <= didx_d;
      ddata_q  <= ddata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      tfr_q    <= tfr_d;
      metric_q <= metric_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_FEATURES); i++) test_q[i] <= '0;
    end else if (test_we_c) begin
      test_q[fcnt_q] <= test_feature;
    end
  end

  // Per-feature term: |test - sample| in DATA_WIDTH+1 bits, squared or passed through.
  always_comb begin
    test_sel_c = test_q[fidx_q[MEM_LATENCY-1]];
    diff_c     = {test_sel_c[DATA_WIDTH-1], test_sel_c} - {sample_data[DATA_WIDTH-1], sample_data};
    absd_c     = diff_c[DATA_WIDTH] ? DATA_WIDTH'(-diff_c) : DATA_WIDTH'(diff_c);
    sq_c       = (2*DATA_WIDTH)'(absd_c) * (2*DATA_WIDTH)'(absd_c);
    term_c     = metric_q ? ACC_W'(absd_c) : ACC_W'(sq_c);
  end

  // Return path: valid/feature-index tags track reads through the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      for (int i = 0; i < int'(MEM_LATENCY); i++) fidx_q[i] <= '0;
      acc_q  <= '0;
      last_q <= 1'b0;
    end else begin
      fidx_q[0] <= fcnt_q;
      for (int i = 1; i < int'(MEM_LATENCY); i++) fidx_q[i] <= fidx_q[i-1];
      if (flush_c) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_en_q;
        for (int i = 1; i < int'(MEM_LATENCY); i++) vld_q[i] <= vld_q[i-1];
      end
      last_q <= !flush_c && vld_q[MEM_LATENCY-1] && (fidx_q[MEM_LATENCY-1] == F_LAST);
      if (acc_clr_c) begin
        acc_q <= '0;
      end else if (vld_q[MEM_LATENCY-1] && !flush_c) begin
        acc_q <= acc_q + term_c;
      end
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign test_feature_ready = tfr_q;
  assign sample_rd_en       = rd_en_q;
  assign sample_addr        = addr_q;
  assign dist_data          = ddata_q;
  assign dist_idx           = didx_q;
  assign dist_valid         = dv_q;

endmodule

// File: tb/tb_knn_distance_engine.sv
// Scoreboard bench for knn_distance_engine: two instances (memory latency 1 and 3),
// directed vectors with hand-computed distances.
module tb_knn_distance_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_s [2];
  logic        abort_s [2];
  logic        metric_s [2];
  logic        tfv_s [2];
  logic        dready_s [2];
  logic [15:0] tf_s [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        tfr_w [2];
  logic        rd_w [2];
  logic        dv_w [2];
  logic [7:0]  addr_w [2];
  logic [33:0] dd_w [2];
  logic        dix_w [2];

  logic [15:0] mem [256];
  logic [15:0] p0;
  logic [15:0] p1 [3];

  logic [34:0] q0 [$];
  logic [34:0] q1 [$];
  logic [34:0] em;
  int checks = 0;
  int errors = 0;
  int done_cnt [2];

  knn_distance_engine #(.DATA_WIDTH(16), .NUM_FEATURES(4), .NUM_SAMPLES(2),
                        .ADDR_WIDTH(8), .MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .metric_sel(metric_s[0]), .busy(busy_w[0]), .done(done_w[0]),
    .test_feature(tf_s[0]), .test_feature_valid(tfv_s[0]), .test_feature_ready(tfr_w[0]),
    .sample_rd_en(rd_w[0]), .sample_addr(addr_w[0]), .sample_data(p0),
    .dist_data(dd_w[0]), .dist_idx(dix_w[0]), .dist_valid(dv_w[0]), .dist_ready(dready_s[0]));

  knn_distance_engine #(.DATA_WIDTH(16), .NUM_FEATURES(4), .NUM_SAMPLES(2),
                        .ADDR_WIDTH(8), .MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .metric_sel(metric_s[1]), .busy(busy_w[1]), .done(done_w[1]),
    .test_feature(tf_s[1]), .test_feature_valid(tfv_s[1]), .test_feature_ready(tfr_w[1]),
    .sample_rd_en(rd_w[1]), .sample_addr(addr_w[1]), .sample_data(p1[2]),
    .dist_data(dd_w[1]), .dist_idx(dix_w[1]), .dist_valid(dv_w[1]), .dist_ready(dready_s[1]));

  // Synchronous memory models with latency 1 and 3
  always @(posedge clk) begin
    p0    <= rd_w[0] ? mem[addr_w[0]] : 16'd0;
    p1[0] <= rd_w[1] ? mem[addr_w[1]] : 16'd0;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_w[0]) done_cnt[0]++;
      if (done_w[1]) done_cnt[1]++;
      if (dv_w[0] && dready_s[0]) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb0_unexpected: got idx %0d data %0d expected no output", dix_w[0], dd_w[0]);
        end else begin
          em = q0.pop_front();
          chk("sb0_dist", 64'({dix_w[0], dd_w[0]}), 64'(em));
        end
      end
      if (dv_w[1] && dready_s[1]) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb1_unexpected: got idx %0d data %0d expected no output", dix_w[1], dd_w[1]);
        end else begin
          em = q1.pop_front();
          chk("sb1_dist", 64'({dix_w[1], dd_w[1]}), 64'(em));
        end
      end
    end
  end

  task automatic set_mem(input logic [63:0] s0, input logic [63:0] s1);
    for (int n = 0; n < 4; n++) begin
      mem[n]     = s0[16*n +: 16];
      mem[4 + n] = s1[16*n +: 16];
    end
  endtask

  task automatic push(input int u, input logic [34:0] e);
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic start_run(input int u, input logic metric, input logic with_abort);
    metric_s[u] = metric;
    start_s[u]  = 1'b1;
    abort_s[u]  = with_abort;
    @(posedge clk); #1;
    start_s[u]  = 1'b0;
    abort_s[u]  = 1'b0;
    chk("start_busy", 64'(busy_w[u]), 64'd1);
  endtask

  task automatic load_test(input int u, input logic [63:0] fv, input logic gaps, input logic pester);
    int k;
    for (int n = 0; n < 4; n++) begin
      if (gaps) begin
        tfv_s[u]   = 1'b0;
        start_s[u] = pester;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        @(posedge clk); #1;
      end
      tf_s[u]  = fv[16*n +: 16];
      tfv_s[u] = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!tfr_w[u] && k < 50);
      if (!tfr_w[u]) chk("load_ready_timeout", 64'(tfr_w[u]), 64'd1);
      @(posedge clk); #1;
    end
    tfv_s[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!done_w[u] && k < 500);
    chk("done_seen", 64'(done_w[u]), 64'd1);
    chk("busy_in_done", 64'(busy_w[u]), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_w[u]), 64'd0);
    chk("idle_after_done", 64'(busy_w[u]), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run(input int u, input logic metric, input logic [63:0] fv,
                     input logic [34:0] e0, input logic [34:0] e1,
                     input logic gaps, input logic pester, input logic with_abort);
    int d0;
    d0 = done_cnt[u];
    push(u, e0);
    push(u, e1);
    start_run(u, metric, with_abort);
    load_test(u, fv, gaps, pester);
    if (pester) begin
      start_s[u] = 1'b1;
      @(posedge clk); #1;
      start_s[u] = 1'b0;
    end
    wait_done(u);
    chk("queue_empty", 64'((u == 0) ? q0.size() : q1.size()), 64'd0);
    chk("one_done", 64'(done_cnt[u] - d0), 64'd1);
  endtask

  localparam logic [63:0] T1_TEST = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] ZERO4   = 64'd0;
  localparam logic [63:0] T3_TEST = {16'd0, 16'd0, 16'h8000, 16'hFFFD};
  localparam logic [63:0] T3_S0   = {16'd0, 16'd0, 16'h7FFF, 16'd4};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; abort_s[u] = 1'b0; metric_s[u] = 1'b0;
      tfv_s[u] = 1'b0; tf_s[u] = 16'd0; dready_s[u] = 1'b1; done_cnt[u] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_busy", 64'(busy_w[u]), 64'd0);
      chk("rst_done", 64'(done_w[u]), 64'd0);
      chk("rst_valid", 64'(dv_w[u]), 64'd0);
      chk("rst_ready", 64'(tfr_w[u]), 64'd0);
      chk("rst_rd_en", 64'(rd_w[u]), 64'd0);
    end
    @(posedge clk); #1;

    // T1 Euclid, T2 Manhattan with abort+start together (start wins)
    set_mem(T1_TEST, ZERO4);
    run(0, 1'b0, T1_TEST, {1'b0, 34'd0}, {1'b1, 34'd30}, 1'b0, 1'b0, 1'b0);
    run(0, 1'b1, T1_TEST, {1'b0, 34'd0}, {1'b1, 34'd10}, 1'b0, 1'b0, 1'b1);

    // T3 extreme difference
    set_mem(T3_S0, T3_TEST);
    run(0, 1'b0, T3_TEST, {1'b0, 34'd4294836274}, {1'b1, 34'd0}, 1'b0, 1'b0, 1'b0);

    // T4 backpressure at idx0
    set_mem(ZERO4, T1_TEST);
    dready_s[0] = 1'b0;
    push(0, {1'b0, 34'd30});
    push(0, {1'b1, 34'd0});
    start_run(0, 1'b0, 1'b0);
    load_test(0, T1_TEST, 1'b0, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!dv_w[0] && k < 200);
    chk("t4_valid", 64'(dv_w[0]), 64'd1);
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", 64'(dv_w[0]), 64'd1);
      chk("t4_hold_data", 64'(dd_w[0]), 64'd30);
      chk("t4_hold_idx", 64'(dix_w[0]), 64'd0);
      chk("t4_no_read", 64'(rd_w[0]), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    dready_s[0] = 1'b1;
    wait_done(0);
    chk("t4_queue_empty", 64'(q0.size()), 64'd0);

    // T5 abort during fetch of sample 1, then rerun T1
    set_mem(T1_TEST, ZERO4);
    push(0, {1'b0, 34'd0});
    start_run(0, 1'b0, 1'b0);
    load_test(0, T1_TEST, 1'b0, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!(rd_w[0] && addr_w[0] == 8'd4) && k < 200);
    chk("t5_fetch_s1_addr", 64'(addr_w[0]), 64'd4);
    d0 = done_cnt[0];
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    chk("t5_abort_busy", 64'(busy_w[0]), 64'd0);
    chk("t5_abort_valid", 64'(dv_w[0]), 64'd0);
    chk("t5_abort_rd", 64'(rd_w[0]), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_done", 64'(done_cnt[0] - d0), 64'd0);
    chk("t5_queue_empty", 64'(q0.size()), 64'd0);
    run(0, 1'b0, T1_TEST, {1'b0, 34'd0}, {1'b1, 34'd30}, 1'b0, 1'b0, 1'b0);

    // T6 latency 3, valid gaps, start pulsed while busy
    run(1, 1'b0, T1_TEST, {1'b0, 34'd0}, {1'b1, 34'd30}, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_idle", 64'(busy_w[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
